// File: rtl/time_chain_counter.sv
// time_chain_counter: hours/minutes/seconds chain with parallel load,
// per-field set-mode adjust and registered rollover carry pulses.
module time_chain_counter #(
  parameter int W        = 6,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_en,
  input  logic [1:0]   mode,
  input  logic         adj_up,
  input  logic         adj_dn,
  input  logic         load,
  input  logic [W-1:0] load_sec,
  input  logic [W-1:0] load_min,
  input  logic [W-1:0] load_hour,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hour,
  output logic         min_carry,
  output logic         day_carry
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SEC  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_HOUR = 2'b11
  } mode_e;

  // Terminal values are compared before incrementing, so a modulus of 2^W
  // never needs a W+1 bit intermediate.
  localparam logic [W-1:0] SEC_MAX  = W'(SEC_MOD - 1);
  localparam logic [W-1:0] MIN_MAX  = W'(MIN_MOD - 1);
  localparam logic [W-1:0] HOUR_MAX = W'(HOUR_MOD - 1);

  // Load range limits need one extra bit so a modulus of 2^W is representable.
  localparam logic [W:0] SEC_LIM  = (W+1)'(SEC_MOD);
  localparam logic [W:0] MIN_LIM  = (W+1)'(MIN_MOD);
  localparam logic [W:0] HOUR_LIM = (W+1)'(HOUR_MOD);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] sec_q, sec_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] hour_q, hour_d;
  logic         min_carry_q, min_carry_d;
  logic         day_carry_q, day_carry_d;
  mode_e        mode_s;

  assign mode_s = mode_e'(mode);

  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] v,
                                           input logic [W-1:0] vmax);
    return (v == vmax) ? '0 : v + ONE;
  endfunction

  function automatic logic [W-1:0] dec_mod(input logic [W-1:0] v,
                                           input logic [W-1:0] vmax);
    return (v == '0) ? vmax : v - ONE;
  endfunction

  function automatic logic [W-1:0] clip_load(input logic [W-1:0] v,
                                             input logic [W:0]   lim);
    return ({1'b0, v} < lim) ? v : '0;
  endfunction

  // Next-state: load beats set-mode adjust, which beats the run tick.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    min_carry_d = 1'b0;
    day_carry_d = 1'b0;
    if (load) begin
      sec_d  = clip_load(load_sec, SEC_LIM);
      min_d  = clip_load(load_min, MIN_LIM);
      hour_d = clip_load(load_hour, HOUR_LIM);
    end else if (mode_s != MODE_RUN) begin
      // Adjust wraps stay inside the selected field; no carries, no borrows.
      if (adj_up && !adj_dn) begin
        case (mode_s)
          MODE_SEC:  sec_d  = inc_mod(sec_q, SEC_MAX);
          MODE_MIN:  min_d  = inc_mod(min_q, MIN_MAX);
          MODE_HOUR: hour_d = inc_mod(hour_q, HOUR_MAX);
          default:   ;
        endcase
      end else if (adj_dn && !adj_up) begin
        case (mode_s)
          MODE_SEC:  sec_d  = dec_mod(sec_q, SEC_MAX);
          MODE_MIN:  min_d  = dec_mod(min_q, MIN_MAX);
          MODE_HOUR: hour_d = dec_mod(hour_q, HOUR_MAX);
          default:   ;
        endcase
      end
    end else if (tick_en) begin
      sec_d = inc_mod(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_carry_d = 1'b1;
        min_d       = inc_mod(min_q, MIN_MAX);
        if (min_q == MIN_MAX) begin
          hour_d = inc_mod(hour_q, HOUR_MAX);
          if (hour_q == HOUR_MAX) begin
            day_carry_d = 1'b1;
          end
        end
      end
    end
  end

  // State and carry registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
    end
  end

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign min_carry = min_carry_q;
  assign day_carry = day_carry_q;

endmodule

// File: tb/tb_time_chain_counter.sv
// Directed bench for time_chain_counter: default 60/60/24 instance plus a
// small 10/6/12 instance for the full-day wrap.
module tb_time_chain_counter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       tick_en, adj_up, adj_dn, load;
  logic [1:0] mode;
  logic [5:0] load_sec, load_min, load_hour;
  logic [5:0] sec, min, hour;
  logic       min_carry, day_carry;

  logic       b_tick;
  logic [3:0] b_sec, b_min, b_hour;
  logic       b_min_carry, b_day_carry;

  int checks = 0;
  int errors = 0;
  int day_cnt;

  always #5 clk = ~clk;

  time_chain_counter dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .mode(mode),
    .adj_up(adj_up), .adj_dn(adj_dn), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .sec(sec), .min(min), .hour(hour),
    .min_carry(min_carry), .day_carry(day_carry)
  );

  time_chain_counter #(.W(4), .SEC_MOD(10), .MIN_MOD(6), .HOUR_MOD(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_en(b_tick), .mode(2'b00),
    .adj_up(1'b0), .adj_dn(1'b0), .load(1'b0),
    .load_sec(4'd0), .load_min(4'd0), .load_hour(4'd0),
    .sec(b_sec), .min(b_min), .hour(b_hour),
    .min_carry(b_min_carry), .day_carry(b_day_carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int s, input int m, input int h,
                          input int mc, input int dc);
    chk({tag, ".sec"}, 32'(sec), 32'(s));
    chk({tag, ".min"}, 32'(min), 32'(m));
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".min_carry"}, 32'(min_carry), 32'(mc));
    chk({tag, ".day_carry"}, 32'(day_carry), 32'(dc));
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tick_en = 1'b0; adj_up = 1'b0; adj_dn = 1'b0; load = 1'b0;
    mode = 2'b00; load_sec = '0; load_min = '0; load_hour = '0; b_tick = 1'b0;
    #2;
    chk_time("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 60 ticks from reset: sec walks 1..59 then wraps with a min carry.
    tick_en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      chk("tick60.sec", 32'(sec), 32'(i % 60));
      chk("tick60.min_carry", 32'(min_carry), (i == 60) ? 32'd1 : 32'd0);
    end
    chk("tick60.min", 32'(min), 32'd1);
    tick_en = 1'b0;
    step();
    chk_time("carry_drop", 0, 1, 0, 0, 0);

    // Run mode without tick: adjust requests are ignored.
    adj_up = 1'b1;
    step();
    chk_time("run_idle", 0, 1, 0, 0, 0);
    adj_up = 1'b0;

    // Load 23:59:59 then one tick for a full wrap.
    load = 1'b1; load_sec = 6'd59; load_min = 6'd59; load_hour = 6'd23;
    step();
    chk_time("load_max", 59, 59, 23, 0, 0);
    load = 1'b0; tick_en = 1'b1;
    step();
    chk_time("full_wrap", 0, 0, 0, 1, 1);
    tick_en = 1'b0;
    step();
    chk_time("wrap_after", 0, 0, 0, 0, 0);

    // Set-min: decrement wraps 0->59, ticks are ignored, no carries.
    mode = 2'b10; adj_dn = 1'b1; tick_en = 1'b1;
    step();
    chk_time("setmin_dn", 0, 59, 0, 0, 0);
    adj_dn = 1'b0;
    step();
    step();
    chk_time("setmin_frozen", 0, 59, 0, 0, 0);
    adj_up = 1'b1;
    step();
    chk_time("setmin_up_wrap", 0, 0, 0, 0, 0);
    adj_up = 1'b0;

    // Set-hour decrement wrap, set-sec with both adjusts, then set-sec down/up.
    mode = 2'b11; adj_dn = 1'b1;
    step();
    chk_time("sethour_dn", 0, 0, 23, 0, 0);
    mode = 2'b01; adj_up = 1'b1;
    step();
    chk_time("setsec_both", 0, 0, 23, 0, 0);
    adj_up = 1'b0;
    step();
    chk_time("setsec_dn", 59, 0, 23, 0, 0);
    adj_dn = 1'b0; adj_up = 1'b1;
    step();
    chk_time("setsec_up_wrap", 0, 0, 23, 0, 0);
    step();
    chk_time("setsec_up", 1, 0, 23, 0, 0);
    adj_up = 1'b0;

    // Load with tick: load wins, out-of-range fields clear, no carry.
    mode = 2'b00; tick_en = 1'b1; load = 1'b1;
    load_sec = 6'd61; load_min = 6'd5; load_hour = 6'd30;
    step();
    chk_time("load_oob", 0, 5, 0, 0, 0);
    load = 1'b0;
    step();
    chk_time("resume_run", 1, 5, 0, 0, 0);
    tick_en = 1'b0;

    // Asynchronous reset between edges at 12:34:56.
    load = 1'b1; load_sec = 6'd56; load_min = 6'd34; load_hour = 6'd12;
    step();
    chk_time("load_1234", 56, 34, 12, 0, 0);
    load = 1'b0; mode = 2'b01; adj_up = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("async_reset", 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    adj_up = 1'b0; mode = 2'b00;
    load = 1'b1; load_sec = 6'd1; load_min = 6'd2; load_hour = 6'd3; tick_en = 1'b1;
    step();
    chk_time("post_reset_load", 1, 2, 3, 0, 0);
    load = 1'b0; tick_en = 1'b0;

    // Small instance: 720 ticks make exactly one day.
    day_cnt = 0;
    b_tick = 1'b1;
    for (int i = 1; i <= 720; i++) begin
      step();
      if (b_day_carry) day_cnt++;
      if (i == 719) begin
        chk("b719.sec", 32'(b_sec), 32'd9);
        chk("b719.min", 32'(b_min), 32'd5);
        chk("b719.hour", 32'(b_hour), 32'd11);
      end
    end
    b_tick = 1'b0;
    chk("b720.day_count", 32'(day_cnt), 32'd1);
    chk("b720.day_carry", 32'(b_day_carry), 32'd1);
    chk("b720.min_carry", 32'(b_min_carry), 32'd1);
    chk("b720.sec", 32'(b_sec), 32'd0);
    chk("b720.min", 32'(b_min), 32'd0);
    chk("b720.hour", 32'(b_hour), 32'd0);
    step();
    chk("b721.day_carry", 32'(b_day_carry), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_chain_counter.md
TIME_CHAIN_COUNTER -- requirements
Module: time_chain_counter

Interface
REQ-001 Parameter W, default 6: width of every time field.
REQ-002 Parameter SEC_MOD, default 60: seconds modulus, 2..2^W.
REQ-003 Parameter MIN_MOD, default 60: minutes modulus, 2..2^W.
REQ-004 Parameter HOUR_MOD, default 24: hours modulus, 2..2^W.
REQ-005 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port tick_en, input, 1: one-second qualifier, sampled on the rising edge of clk.
REQ-008 Port mode, input, 2: 00 run, 01 set-sec, 10 set-min, 11 set-hour.
REQ-009 Port adj_up, input, 1: increment the selected field while in a set mode.
REQ-010 Port adj_dn, input, 1: decrement the selected field while in a set mode.
REQ-011 Port load, input, 1: parallel load of all fields.
REQ-012 Port load_sec / load_min / load_hour, input, W each: parallel load values.
REQ-013 Port sec / min / hour, output, W each: registered time fields.
REQ-014 Port min_carry, output, 1: one-cycle pulse on seconds-to-minutes rollover.
REQ-015 Port day_carry, output, 1: one-cycle pulse on hours wrap to 0.

Function
REQ-016 All outputs are registered; a field change is visible the cycle after the edge on which the event is sampled.
REQ-017 Priority is fixed: reset, then load, then set-mode adjust, then run tick.
REQ-018 Load: on an edge with load=1, each field takes its load value.
REQ-019 Load range check: any load value >= its modulus loads as 0, with no carry pulses.
REQ-020 Run mode (mode=00) with tick_en=1: sec increments by 1.
REQ-021 Seconds rollover: sec=SEC_MOD-1 wraps to 0 and min increments on the same edge.
REQ-022 Minutes rollover: min=MIN_MOD-1 with a seconds rollover wraps min to 0 and increments hour on the same edge.
REQ-023 Hours rollover: hour=HOUR_MOD-1 with a minutes rollover wraps hour to 0; a full wrap takes all three fields to 0 on one edge.
REQ-024 min_carry is 1 for exactly the cycle in which the wrapped sec=0 is first presented; otherwise 0.
REQ-025 day_carry is 1 for exactly the cycle in which the wrapped hour=0 is first presented; otherwise 0.
REQ-026 Run mode with tick_en=0: no field changes.
REQ-027 Set modes (mode != 00): tick_en is ignored and time is frozen; ticks arriving in a set mode are not accumulated.
REQ-028 Set mode, adj_up=1, adj_dn=0: the selected field increments modulo its own modulus.
REQ-029 Set mode, adj_dn=1, adj_up=0: the selected field decrements; 0 wraps to MOD-1.
REQ-030 Adjust edges: adjust wraps never carry into or borrow from another field and never assert min_carry or day_carry.
REQ-031 Set mode with adj_up=adj_dn=1, or both 0: no change.
REQ-032 adj_up and adj_dn are level-sampled: one step per clock edge while asserted; edge detection is the caller's duty.
REQ-033 Run mode: adj_up and adj_dn are ignored.
REQ-034 Mode change takes effect on the edge on which it is sampled.
REQ-035 Returning to run mode: counting resumes with the next tick_en, and the sub-second phase is not restored.
REQ-036 All arithmetic is W bits, compare-before-increment; no field ever holds a value >= its modulus.

Reset
REQ-037 rst_n=0 asynchronously forces sec=0, min=0, hour=0, min_carry=0 and day_carry=0, regardless of clk.
REQ-038 Reset asserted mid-adjust or mid-rollover discards the operation; the first edge after release obeys REQ-017.

Verification
REQ-039 Reset then 60 tick_en pulses, defaults -> sec 0..59 then 0, min=1, min_carry high one cycle.
REQ-040 load 59/59/23, then one tick_en -> sec=min=hour=0, min_carry=day_carry=1 same cycle, both 0 next cycle.
REQ-041 mode=10, min=0, adj_dn one edge -> min=59, hour unchanged, no carries; tick_en pulses during this leave sec unchanged.
REQ-042 load_sec=61 with load=1 and tick_en=1 -> sec=0 (load wins, out-of-range cleared), no min_carry.
REQ-043 rst_n pulled low between clk edges at 12:34:56 -> outputs 0 immediately, before the next edge.
REQ-044 SEC_MOD=10, MIN_MOD=6, HOUR_MOD=12, W=4: 720 ticks from 0 -> exactly one day_carry and all fields return to 0.
